// File: rtl/dip_pkg.sv
// -----------------------------------------------------------------------------
// dip_pkg
//
// Shared definitions for the DIP switch conditioning block.
//
// Contents:
//   dip_state_e            top-level state: INIT (settle, no debounce) / RUN
//   DIP_WIDTH              default number of switch bits on the trainer
//   DEBOUNCE_CYCLES_50MHZ  default stability window, 1 ms at a 50 MHz clock
// -----------------------------------------------------------------------------
package dip_pkg;

    // Default switch count on the trainer board.
    localparam int DIP_WIDTH = 8;

    // 1 ms worth of 50 MHz clocks: long enough to ride out mechanical bounce.
    localparam int DEBOUNCE_CYCLES_50MHZ = 50000;

    // INIT: copy the synchronised pins straight through while the settle
    //       counter runs, so the first published vector is the real one.
    // RUN : per-bit debounce with edge strobes.
    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } dip_state_e;

endpackage : dip_pkg

// File: rtl/dip_debounce_bit.sv
// -----------------------------------------------------------------------------
// dip_debounce_bit
//
// One switch bit: two-flop synchroniser, stability counter and stable flop.
//
// Parameters:
//   STABLE_CYCLES  cycles the synchronised bit must differ from the stable
//                  value before the new value is accepted (>= 2).
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high clear
//   raw     in   unsynchronised switch pin
//   run     in   1 = debounce active; 0 = stable follows the synchroniser
//                with no strobes (settle period)
//   stable  out  debounced bit
//   rise    out  one-cycle pulse when stable goes 0 -> 1
//   fall    out  one-cycle pulse when stable goes 1 -> 0
// -----------------------------------------------------------------------------
module dip_debounce_bit
    import dip_pkg::*;
#(
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic run,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Synchroniser stages: nothing may sit between s1 and s2.
    logic s1_q;
    logic s2_q;

    logic             stable_q, stable_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;

        if (!run) begin
            // Settle period: track the pin directly, never strobe.
            stable_d = s2_q;
            cnt_d    = '0;
        end else if (s2_q == stable_q) begin
            // Any return to the stable value throws away accumulated time.
            cnt_d = '0;
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            // Differed for a full window: accept. Counter saturates here and
            // is cleared rather than wrapping.
            stable_d = s2_q;
            cnt_d    = '0;
            rise_d   = s2_q;
            fall_d   = ~s2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;

endmodule : dip_debounce_bit

// File: rtl/dip_debounce.sv
// -----------------------------------------------------------------------------
// dip_debounce
//
// Conditions the trainer DIP switches before the switch-to-LED logic.
// Each bit is synchronised and debounced independently; the top owns the
// INIT/RUN sequencing, the settle counter and the aggregate strobes.
//
// Parameters:
//   WIDTH          number of switch bits
//   STABLE_CYCLES  debounce window and settle period in clocks (>= 2)
//
// Ports:
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   dip_raw     in   raw switch pins [WIDTH]
//   dip_stable  out  debounced switch vector [WIDTH]
//   rise        out  per-bit one-cycle 0->1 strobes [WIDTH]
//   fall        out  per-bit one-cycle 1->0 strobes [WIDTH]
//   changed     out  one-cycle pulse when any bit rose or fell
//   ready       out  high once the initial settle period has elapsed
// -----------------------------------------------------------------------------
module dip_debounce
    import dip_pkg::*;
#(
    parameter int WIDTH         = DIP_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dip_raw,
    output logic [WIDTH-1:0] dip_stable,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             ready
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // A one-cycle window would make the counter zero bits wide.
    if (STABLE_CYCLES < 2) begin : g_bad_param
        $error("dip_debounce: STABLE_CYCLES must be 2 or more");
    end

    dip_state_e       state_q,  state_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic             ready_q,  ready_d;
    logic             run;

    // ---------------------------------------------------------------------
    // Sequencer: INIT counts out one full window so the synchronisers and
    // the pins have settled before debouncing (and strobing) begins.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= INIT;
            settle_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            ready_q  <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        ready_d  = ready_q;

        unique case (state_q)
            INIT: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    settle_d = settle_q + CNT_ONE;
                end
            end
            RUN: begin
                // Stays here until reset.
                ready_d = 1'b1;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // The bits see RUN only from the cycle after the transition edge, so the
    // INIT-to-RUN edge itself still copies the pins and cannot strobe.
    assign run = (state_q == RUN);

    // ---------------------------------------------------------------------
    // Per-bit debouncers
    // ---------------------------------------------------------------------
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        dip_debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (dip_raw[gi]),
            .run    (run),
            .stable (dip_stable[gi]),
            .rise   (rise[gi]),
            .fall   (fall[gi])
        );
    end

    // Built from registered strobes, so it lines up with them exactly and is
    // a single pulse however many bits flip together.
    assign changed = |(rise | fall);
    assign ready   = ready_q;

endmodule : dip_debounce

// File: tb/tb_dip_debounce.sv
// -----------------------------------------------------------------------------
// tb_dip_debounce
//
// Directed stimulus with a scoreboard: every expected strobe event (stable
// vector, rise, fall, edge number) is queued when the stimulus is applied; a
// monitor pops and compares whenever the DUT shows any strobe.
// -----------------------------------------------------------------------------
module tb_dip_debounce;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] dip_raw = 8'h0F;
    logic [W-1:0] dip_stable;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;
    logic         ready;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic [7:0]  stable;
        logic [7:0]  rise;
        logic [7:0]  fall;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    dip_debounce #(
        .WIDTH         (W),
        .STABLE_CYCLES (S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dip_raw    (dip_raw),
        .dip_stable (dip_stable),
        .rise       (rise),
        .fall       (fall),
        .changed    (changed),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    // Counts rising edges; at a negedge, cyc is the number of the last edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end else begin
            $display("ok   %s value=%0h t=%0t", name, act, $time);
        end
    endtask

    // Drive a new raw vector just after an edge; the event (if any) lands
    // S+1 edges after the next (sampling) edge.
    task automatic drive(input logic [7:0] v, input bit expect_evt,
                         input logic [7:0] st, input logic [7:0] r, input logic [7:0] f);
        exp_t x;
        if (expect_evt) begin
            x.stable = st;
            x.rise   = r;
            x.fall   = f;
            x.cyc    = 32'(cyc + 1 + S + 1);
            exp_q.push_back(x);
        end
        dip_raw = v;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Check that ready rises exactly S edges after reset release.
    task automatic check_settle(input logic [7:0] st_req);
        for (int k = 1; k <= S; k++) begin
            @(negedge clk);
            chk($sformatf("ready_after_%0d", k), 32'(ready), (k == S) ? 32'd1 : 32'd0);
        end
        chk("stable_after_settle", 32'(dip_stable), 32'(st_req));
    endtask

    // Monitor: any strobe activity must match the head of the scoreboard.
    always @(negedge clk) begin
        if (changed || (rise != '0) || (fall != '0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe stable=%0h rise=%0h fall=%0h changed=%0b required=none cyc=%0d",
                         dip_stable, rise, fall, changed, cyc);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (dip_stable !== e.stable || rise !== e.rise || fall !== e.fall ||
                    changed !== 1'b1 || 32'(cyc) !== e.cyc) begin
                    errors++;
                    $display("FAIL strobe_event actual stable=%0h rise=%0h fall=%0h changed=%0b cyc=%0d required stable=%0h rise=%0h fall=%0h changed=1 cyc=%0d",
                             dip_stable, rise, fall, changed, cyc, e.stable, e.rise, e.fall, e.cyc);
                end else begin
                    $display("ok   strobe_event stable=%0h rise=%0h fall=%0h cyc=%0d",
                             dip_stable, rise, fall, cyc);
                end
            end
        end
    end

    initial begin
        #20000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        // Reset then settle with pins at 0F.
        wait_cyc(3);
        chk("rst_stable",  32'(dip_stable), 32'h00);
        chk("rst_ready",   32'(ready),      32'h0);
        chk("rst_strobes", 32'({rise, fall, changed}), 32'h0);
        rst = 1'b0;
        check_settle(8'h0F);
        wait_cyc(2);

        // Clean change 0F -> 8F.
        drive(8'h8F, 1'b1, 8'h8F, 8'h80, 8'h00);
        wait_cyc(10);

        // Bit 0 low for 3 cycles: rejected.
        drive(8'h8E, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_cyc(3);
        drive(8'h8F, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_cyc(8);
        chk("glitch3_stable", 32'(dip_stable), 32'h8F);

        // Bit 0 low for 4 cycles: accepted, then the return is accepted too.
        drive(8'h8E, 1'b1, 8'h8E, 8'h00, 8'h01);
        wait_cyc(4);
        drive(8'h8F, 1'b1, 8'h8F, 8'h01, 8'h00);
        wait_cyc(10);

        // Bounce bit 3 every 2 cycles for 20 cycles, then hold low.
        for (int p = 0; p < 10; p++) begin
            drive((p % 2 == 0) ? 8'h87 : 8'h8F, 1'b0, 8'h00, 8'h00, 8'h00);
            wait_cyc(2);
        end
        drive(8'h87, 1'b1, 8'h87, 8'h00, 8'h08);
        wait_cyc(10);
        drive(8'h8F, 1'b1, 8'h8F, 8'h08, 8'h00);
        wait_cyc(10);

        // Multi-bit step 8F -> 70.
        drive(8'h70, 1'b1, 8'h70, 8'h70, 8'h8F);
        wait_cyc(10);

        // Reset mid-count.
        drive(8'h0F, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_cyc(2);
        #2 rst = 1'b1;
        #1;
        chk("midrst_stable", 32'(dip_stable), 32'h00);
        chk("midrst_ready",  32'(ready),      32'h0);
        wait_cyc(2);
        rst = 1'b0;
        check_settle(8'h0F);
        wait_cyc(10);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dip_debounce
